// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp/msip on the peripheral bus, drives MTIP/MSIP into mip.
// Latency: bus access completes one cycle after acceptance; MTIP lags mtime/mtimecmp by one cycle.
// Backpressure: none; an access is taken whenever bus_sel=1 and bus_ready=0.
module clint_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [15:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic [31:0] mip_out,
    output logic [63:0] mtime_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

    localparam logic [13:0] A_MSIP   = 14'h0000;
    localparam logic [13:0] A_CMP_LO = 14'h1000;
    localparam logic [13:0] A_CMP_HI = 14'h1001;
    localparam logic [13:0] A_MT_LO  = 14'h2FFE;
    localparam logic [13:0] A_MT_HI  = 14'h2FFF;

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   cmp_q, cmp_d;
    logic          msip_q, msip_d;
    logic          mtip_q, mtip_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          accept;
    logic          wr;
    logic          tick;
    logic [13:0]   word;
    logic [31:0]   rd_mux;
    logic          addr_unused;

    // Byte lanes below the word boundary are not decoded.
    assign addr_unused = ^bus_addr[1:0];

    always_comb begin
        accept  = bus_sel & ~ready_q;
        wr      = accept & bus_we;
        word    = bus_addr[15:2];
        tick    = (presc_q == PS_MAX);

        presc_d = tick ? '0 : presc_q + 1'b1;

        case (word)
            A_MSIP:   rd_mux = {31'b0, msip_q};
            A_CMP_LO: rd_mux = cmp_q[31:0];
            A_CMP_HI: rd_mux = cmp_q[63:32];
            A_MT_LO:  rd_mux = mtime_q[31:0];
            A_MT_HI:  rd_mux = mtime_q[63:32];
            default:  rd_mux = 32'b0;
        endcase

        // A bus write to mtime overrides the increment on the same edge.
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        cmp_d   = cmp_q;
        msip_d  = msip_q;
        if (wr) begin
            case (word)
                A_MSIP:   msip_d  = bus_wdata[0];
                A_CMP_LO: cmp_d   = {cmp_q[63:32], bus_wdata};
                A_CMP_HI: cmp_d   = {bus_wdata, cmp_q[31:0]};
                A_MT_LO:  mtime_d = {mtime_q[63:32], bus_wdata};
                A_MT_HI:  mtime_d = {bus_wdata, mtime_q[31:0]};
                default:  ;
            endcase
        end

        mtip_d  = (mtime_q >= cmp_q);
        ready_d = accept;
        rdata_d = accept ? rd_mux : 32'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            mtime_q <= 64'd0;
            cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q  <= 1'b0;
            mtip_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'b0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            msip_q  <= msip_d;
            mtip_q  <= mtip_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus_ready = ready_q;
    assign bus_rdata = rdata_q;
    assign mip_out   = {24'b0, mtip_q, 3'b0, msip_q, 3'b0};
    assign mtime_o   = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboarded bench for clint_timer: one instance at TICK_DIV=1, one at TICK_DIV=4.
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        rst1_n = 1'b0, rst4_n = 1'b0;
    logic        sel1 = 1'b0, we1 = 1'b0, sel4 = 1'b0, we4 = 1'b0;
    logic [15:0] addr1 = '0, addr4 = '0;
    logic [31:0] wd1 = '0, wd4 = '0;
    logic [31:0] rd1, rd4, mip1, mip4;
    logic        rdy1, rdy4;
    logic [63:0] mt1, mt4;

    int checks = 0;
    int errors = 0;
    int pulses1 = 0;
    logic [32:0] q1[$];
    logic [32:0] q4[$];

    always #5 clk = ~clk;

    clint_timer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .reset_n(rst1_n), .bus_sel(sel1), .bus_we(we1), .bus_addr(addr1),
        .bus_wdata(wd1), .bus_rdata(rd1), .bus_ready(rdy1), .mip_out(mip1), .mtime_o(mt1)
    );

    clint_timer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset_n(rst4_n), .bus_sel(sel4), .bus_we(we4), .bus_addr(addr4),
        .bus_wdata(wd4), .bus_rdata(rd4), .bus_ready(rdy4), .mip_out(mip4), .mtime_o(mt4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every ready pulse pops one expectation; rdata must be 0 outside pulses.
    always @(negedge clk) begin
        if (rdy1) begin
            pulses1++;
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_ready: rdata %h with no access pending", rd1);
            end else begin
                logic [32:0] e;
                e = q1.pop_front();
                if (e[32]) chk("dut1_rdata", {32'b0, rd1}, {32'b0, e[31:0]});
            end
        end else if (rd1 !== 32'b0) begin
            chk("dut1_rdata_idle", {32'b0, rd1}, 64'd0);
        end
    end

    always @(negedge clk) begin
        if (rdy4) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut4_unexpected_ready: rdata %h with no access pending", rd4);
            end else begin
                logic [32:0] e;
                e = q4.pop_front();
                if (e[32]) chk("dut4_rdata", {32'b0, rd4}, {32'b0, e[31:0]});
            end
        end else if (rd4 !== 32'b0) begin
            chk("dut4_rdata_idle", {32'b0, rd4}, 64'd0);
        end
    end

    // Called at a negedge; returns at the negedge where the ready pulse is visible.
    task automatic bus(input int w, input logic we, input logic [15:0] a,
                       input logic [31:0] d, input logic [31:0] exp);
        int n;
        logic r;
        if (w == 1) begin
            q1.push_back({~we, exp});
            sel1 = 1'b1; we1 = we; addr1 = a; wd1 = d;
        end else begin
            q4.push_back({~we, exp});
            sel4 = 1'b1; we4 = we; addr4 = a; wd4 = d;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            r = (w == 1) ? rdy1 : rdy4;
        end while (!r && n < 8);
        if (!r) begin
            checks++; errors++;
            $display("FAIL bus_timeout: dut%0d addr %h no ready within 8 cycles", w, a);
        end
        if (w == 1) sel1 = 1'b0; else sel4 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // TICK_DIV=4: 40 cycles from reset gives mtime=10
        @(negedge clk);
        rst4_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("div4_mtime_40cyc", mt4, 64'd10);
        bus(4, 1'b0, 16'hBFF8, 32'h0, 32'h0000_000A);
        // Write lands on the tick edge: no increment, prescaler phase kept
        @(negedge clk);
        @(negedge clk);
        bus(4, 1'b1, 16'hBFF8, 32'h0000_0100, 32'h0);
        chk("div4_write_at_tick", mt4, 64'h100);
        repeat (3) @(negedge clk);
        chk("div4_hold_after_write", mt4, 64'h100);
        @(negedge clk);
        chk("div4_next_tick", mt4, 64'h101);

        // Reset values and reset during an access
        chk("rst_mip", {32'b0, mip1}, 64'd0);
        chk("rst_ready", {63'b0, rdy1}, 64'd0);
        chk("rst_mtime", mt1, 64'd0);
        rst1_n = 1'b1;
        @(negedge clk);
        sel1 = 1'b1; we1 = 1'b0; addr1 = 16'h4004;
        @(posedge clk);
        #2 rst1_n = 1'b0;
        @(negedge clk);
        chk("midacc_ready", {63'b0, rdy1}, 64'd0);
        chk("midacc_mtime", mt1, 64'd0);
        chk("midacc_mip", {32'b0, mip1}, 64'd0);
        sel1 = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'b0, rdy1}, 64'd0);
        bus(1, 1'b0, 16'h4004, 32'h0, 32'hFFFF_FFFF);

        // MTIP rise and fall
        bus(1, 1'b1, 16'h4004, 32'h0, 32'h0);
        bus(1, 1'b1, 16'hBFF8, 32'h0, 32'h0);
        chk("mtime_write_lo", mt1, 64'd0);
        bus(1, 1'b1, 16'h4000, 32'd20, 32'h0);
        n = 0;
        while (mt1 != 64'd20 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mtime_reached_20", mt1, 64'd20);
        chk("mtip_at_20", {63'b0, mip1[7]}, 64'd0);
        @(negedge clk);
        chk("mtip_rise", {63'b0, mip1[7]}, 64'd1);
        chk("mtime_21", mt1, 64'd21);
        bus(1, 1'b1, 16'h4000, 32'd100, 32'h0);
        chk("mtip_before_fall", {63'b0, mip1[7]}, 64'd1);
        @(negedge clk);
        chk("mtip_fall", {63'b0, mip1[7]}, 64'd0);

        // MSIP
        bus(1, 1'b1, 16'h0000, 32'hFFFF_FFFF, 32'h0);
        chk("msip_set_mip", {32'b0, mip1}, 64'h8);
        bus(1, 1'b0, 16'h0000, 32'h0, 32'h0000_0001);
        bus(1, 1'b1, 16'h0000, 32'h0, 32'h0);
        chk("msip_clr_mip", {32'b0, mip1}, 64'h0);

        // mtime wrap with cmp all-ones
        bus(1, 1'b1, 16'h4004, 32'hFFFF_FFFF, 32'h0);
        bus(1, 1'b1, 16'h4000, 32'hFFFF_FFFF, 32'h0);
        bus(1, 1'b1, 16'hBFFC, 32'hFFFF_FFFF, 32'h0);
        bus(1, 1'b1, 16'hBFF8, 32'hFFFF_FFFE, 32'h0);
        chk("wrap_m2", mt1, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap_m2_mtip", {63'b0, mip1[7]}, 64'd0);
        @(negedge clk);
        chk("wrap_m1", mt1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_m1_mtip", {63'b0, mip1[7]}, 64'd0);
        @(negedge clk);
        chk("wrap_0", mt1, 64'd0);
        chk("wrap_0_mtip", {63'b0, mip1[7]}, 64'd1);
        @(negedge clk);
        chk("wrap_1", mt1, 64'd1);
        chk("wrap_1_mtip", {63'b0, mip1[7]}, 64'd0);

        // bus_sel held 6 cycles on an unmapped address
        repeat (3) q1.push_back({1'b1, 32'h0});
        pulses1 = 0;
        sel1 = 1'b1; we1 = 1'b0; addr1 = 16'h1234;
        repeat (6) @(negedge clk);
        sel1 = 1'b0;
        chk("held_sel_pulses", pulses1, 64'd3);
        @(negedge clk);

        // Write at a tick edge (every edge ticks at TICK_DIV=1)
        bus(1, 1'b1, 16'hBFF8, 32'h1234_5678, 32'h0);
        chk("write_at_tick", mt1, 64'h0000_0000_1234_5678);
        bus(1, 1'b0, 16'hBFF8, 32'h0, 32'h1234_5679);
        bus(1, 1'b0, 16'hBFFC, 32'h0, 32'h0);

        repeat (3) @(negedge clk);
        chk("dut1_queue_empty", q1.size(), 64'd0);
        chk("dut4_queue_empty", q4.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
